nrzi_tx: RTL and testbench
==========================

NRZI_TX -- requirements
Module: nrzi_tx

Interface
- REQ-001: Parameter WORD_W, default 8, shall set the data word width in bits (range 2..16).
- REQ-002: clk  input  1  sole clock; all state changes on its rising edge.
- REQ-003: reset  input  1  synchronous, active-high reset.
- REQ-004: data  input  WORD_W  word to transmit; sent LSB first.
- REQ-005: valid  input  1  data qualifier from the upstream source.
- REQ-006: ready  output  1  block can accept a word this cycle.
- REQ-007: line  output  1  registered NRZI serial line.
- REQ-008: busy  output  1  high whenever a word is being shifted out (state != IDLE).

Function
- REQ-009: A word shall be accepted on a rising edge where valid && ready; data shall be captured into a shift register on that edge.
- REQ-010: States shall be IDLE, SHIFT and, when stuffing is enabled, STUFF; an accept moves IDLE->SHIFT with bit counter = 0.
- REQ-011: NRZI rule: each SHIFT-cycle edge applies line <= line ^ current_bit, so a 1 toggles the line and a 0 holds it.
- REQ-012: Latency: with an accept at edge N, bit k shall be reflected on line after edge N+1+k, with no gap cycles.
- REQ-013: ready shall be high in IDLE, and in SHIFT when counter == WORD_W-1 and no stuff bit follows.
- REQ-014: An accept in the last-bit cycle shall reload the shift register and restart counter = 0 for back-to-back streaming with zero idle bits.
- REQ-015: Without such an accept, the last bit shall return the block to IDLE.
- REQ-016: In IDLE, line shall hold its last value.
- REQ-017: data and valid shall be ignored while ready is low; changing data mid-word shall not affect line.
- REQ-018: When busy is high, ready shall be low except in the final bit or stuff cycle of a word.

Reset
- REQ-019: While reset is high, line = 0, busy = 0, ready = 0, state = IDLE, and counters and shift register = 0.
- REQ-020: Reset mid-word shall discard the word; the first cycle after reset deasserts shall have ready = 1 and line = 0.
- REQ-021: Reset shall have priority over a simultaneous valid && ready.

Configuration
- REQ-022: Macro NRZI_TX_STUFF_EN shall compile in bit stuffing.
- REQ-023: With NRZI_TX_STUFF_EN, after 6 consecutive transmitted 1s the next cycle shall be STUFF, which inserts a 0 (line holds), does not advance the bit counter, and resets the ones count.
- REQ-024: With NRZI_TX_STUFF_EN, the ones count shall persist across back-to-back words and clear on entering IDLE.
- REQ-025: With NRZI_TX_STUFF_EN, a STUFF cycle following the last bit shall carry the ready/accept opportunity of REQ-013/014.
- REQ-026: Without NRZI_TX_STUFF_EN, there shall be no STUFF state and no ones counter, and words shall occupy exactly WORD_W cycles.

Structure
- REQ-027: Package nrzi_pkg shall hold the state typedef (IDLE, SHIFT, STUFF), STUFF_LIMIT = 6 and the default word width.
- REQ-028: Sub-module nrzi_stuff_ctr (the ones counter plus stuff-request output) shall be instantiated only under NRZI_TX_STUFF_EN; all other logic shall stay flat in nrzi_tx.

Verification
- REQ-029: Reset, then send 8'hA5 -> line = 1,1,0,0,0,1,1,0 after edges N+1..N+8; busy high for 8 cycles; ready high in the bit-7 cycle.
- REQ-030: Stuffing off, send 8'hFF then 8'h00 back-to-back -> line toggles 8 times then holds 0 for 8 cycles, with no gap cycle between words.
- REQ-031: NRZI_TX_STUFF_EN, send 8'hFF -> 9 bit cycles, line = 1,0,1,0,1,0,0(stuff),1,0.
- REQ-032: Assert reset during bit 3 of 8'hF0 -> next cycle line = 0, busy = 0; the following cycle ready = 1.
- REQ-033: Hold valid high and toggle data while busy -> only the word captured at accept appears on line.
- REQ-034: Random back-to-back words through a transition-detect model (output 1 on line change) -> recovered bit stream equals the sent LSB-first stream, with stuff bits removed when enabled.

Source files
------------

// File: rtl/nrzi_pkg.sv
// Shared types and constants for the NRZI serial transmitter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package nrzi_pkg;

  // Transmitter states. STUFF is only reachable when bit stuffing is compiled in.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } state_t;

  // Number of consecutive transmitted 1s that forces an inserted 0.
  localparam int STUFF_LIMIT = 6;

  // Default data word width in bits.
  localparam int WORD_W_DEF = 8;

  // Width of the consecutive-ones counter (must hold STUFF_LIMIT).
  localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

endpackage

// File: rtl/nrzi_stuff_ctr.sv
// Consecutive-ones counter that requests a stuffed 0 after STUFF_LIMIT transmitted 1s.
// Latency: stuff_req is combinational from the current bit and the registered count.
// Backpressure: none; the parent FSM decides when bits are shifted.
module nrzi_stuff_ctr
  import nrzi_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic shift_en,
  input  logic bit_in,
  output logic stuff_req
);

  logic [ONES_W-1:0] ones;

  // Count transmitted 1s; any 0, stuff cycle or idle cycle clears the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      ones <= '0;
    end else if (shift_en && bit_in) begin
      ones <= ones + ONES_W'(1);
    end else begin
      ones <= '0;
    end
  end

  // The bit going out now completes the run, so the next cycle must be a stuff cycle.
  always_comb begin
    stuff_req = shift_en && bit_in && (ones == ONES_W'(STUFF_LIMIT - 1));
  end

endmodule

// File: rtl/nrzi_tx.sv
// NRZI serial transmitter: shifts words out LSB first, a 1 toggles line, a 0 holds it.
// Latency: bit k of a word accepted at edge N appears on line after edge N+1+k.
// Backpressure: ready only in IDLE or the final bit/stuff cycle; NRZI_TX_STUFF_EN adds bit stuffing.
module nrzi_tx
  import nrzi_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              line,
  output logic              busy
);

  localparam int              CNT_W    = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] sreg_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              line_nxt;
  logic              rdy_raw;
  logic              last_bit;

`ifdef NRZI_TX_STUFF_EN
  // Remembers that the stuff cycle in progress follows the last bit of a word.
  logic word_done;
  logic word_done_nxt;
  logic stuff_req;

  nrzi_stuff_ctr u_stuff_ctr (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (state == SHIFT),
    .bit_in    (sreg[0]),
    .stuff_req (stuff_req)
  );
`endif

  assign last_bit = (cnt == LAST_CNT);

  // Next-state, datapath and handshake decode; every path starts from hold values.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    line_nxt  = line;
    rdy_raw   = 1'b0;
`ifdef NRZI_TX_STUFF_EN
    word_done_nxt = word_done;
`endif

    case (state)
      IDLE: begin
        rdy_raw = 1'b1;
        if (valid) begin
          sreg_nxt  = data;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        line_nxt = line ^ sreg[0];
        sreg_nxt = sreg >> 1;
`ifdef NRZI_TX_STUFF_EN
        if (stuff_req) begin
          // The handshake moves to the stuff cycle when it follows the last bit.
          state_nxt     = STUFF;
          word_done_nxt = last_bit;
          if (!last_bit) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end else
`endif
        if (last_bit) begin
          rdy_raw = 1'b1;
          if (valid) begin
            // Back-to-back word: reload with no idle bit in between.
            sreg_nxt = data;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

`ifdef NRZI_TX_STUFF_EN
      STUFF: begin
        // Inserted 0: line holds and the bit counter does not advance.
        word_done_nxt = 1'b0;
        if (word_done) begin
          rdy_raw = 1'b1;
          if (valid) begin
            sreg_nxt  = data;
            cnt_nxt   = '0;
            state_nxt = SHIFT;
          end else begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end else begin
          state_nxt = SHIFT;
        end
      end
`endif

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any simultaneous handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      line  <= 1'b0;
`ifdef NRZI_TX_STUFF_EN
      word_done <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      line  <= line_nxt;
`ifdef NRZI_TX_STUFF_EN
      word_done <= word_done_nxt;
`endif
    end
  end

  // Handshake is held off while reset is asserted.
  always_comb begin
    ready = rdy_raw && !reset;
    busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_nrzi_tx.sv
// Scoreboard bench for nrzi_tx: expected line values and bits are queued at accept time.
// Latency: monitor compares one line value per busy cycle, sampled on the falling edge.
// Backpressure: words are offered with valid and held until ready is seen.
module tb_nrzi_tx;
  import nrzi_pkg::*;

  localparam int W = 8;

`ifdef NRZI_TX_STUFF_EN
  localparam logic [31:0] FF_LINES = 32'h0000_0095;  // 1,0,1,0,1,0,0(stuff),1,0
  localparam int          FF_N     = 9;
`else
  localparam logic [31:0] FF_LINES = 32'h0000_0055;  // 1,0,1,0,1,0,1,0
  localparam int          FF_N     = 8;
`endif

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] data  = '0;
  logic         valid = 1'b0;
  logic         ready;
  logic         line;
  logic         busy;

  nrzi_tx #(.WORD_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .line  (line),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_line_q[$];
  logic exp_bit_q[$];
  logic model_line = 1'b0;
  int   model_ones = 0;
  logic busy_q = 1'b0;
  logic rst_q  = 1'b1;
  logic mon_prev_line = 1'b0;
  int   mon_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-computed line values, first value in bit 0.
  task automatic push_hand(input logic [31:0] lv, input int n);
    for (int i = 0; i < n; i++) exp_line_q.push_back(lv[i]);
  endtask

  task automatic push_bits(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) exp_bit_q.push_back(w[i]);
  endtask

  // Reference NRZI encoder for the first nkeep bits of a word.
  task automatic push_model(input logic [W-1:0] w, input int nkeep);
    for (int i = 0; i < W; i++) begin
      if (i < nkeep) begin
        model_line = model_line ^ w[i];
        exp_line_q.push_back(model_line);
        exp_bit_q.push_back(w[i]);
`ifdef NRZI_TX_STUFF_EN
        model_ones = w[i] ? model_ones + 1 : 0;
        if (model_ones == STUFF_LIMIT) begin
          exp_line_q.push_back(model_line);
          model_ones = 0;
        end
`endif
      end
    end
  endtask

  // Called on a falling edge; returns just after the accepting rising edge.
  task automatic accept_word(input logic [W-1:0] w);
    bit ok;
    ok    = 1'b0;
    data  = w;
    valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (ready === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: ready never seen for word %h", w);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy still %b", busy);
    end
  endtask

  // Values of busy/reset during the cycle that ends at each rising edge.
  always @(posedge clk) begin
    busy_q <= busy;
    rst_q  <= reset;
  end

  // Monitor: each busy cycle yields one line value and one transition-detected bit.
  always @(negedge clk) begin : monitor
    logic e;
    logic rec;
    if (busy_q && !rst_q) begin
      if (exp_line_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL line_unexpected: busy cycle with no queued value, line=%b", line);
      end else begin
        e = exp_line_q.pop_front();
        check("line", 32'(line), 32'(e));
      end
      rec = line ^ mon_prev_line;
`ifdef NRZI_TX_STUFF_EN
      if (mon_run == STUFF_LIMIT) begin
        check("stuff_zero", 32'(rec), 32'd0);
        mon_run = 0;
      end else
`endif
      begin
        if (exp_bit_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL bit_unexpected: recovered %b with no queued bit", rec);
        end else begin
          e = exp_bit_q.pop_front();
          check("recovered_bit", 32'(rec), 32'(e));
        end
        mon_run = rec ? mon_run + 1 : 0;
      end
    end else begin
      mon_run = 0;
    end
    mon_prev_line = line;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    time          t0;
    time          t1;
    logic [W-1:0] w;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_line", 32'(line), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_ready", 32'(ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", 32'(ready), 32'd1);
    check("post_reset_line", 32'(line), 32'd0);

    // 8'hA5: lines 1,1,0,0,0,1,1,0; busy for 8 cycles; ready only in bit 7.
    accept_word(8'hA5);
    push_hand(32'h63, 8);
    push_bits(8'hA5);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) valid = 1'b0;
      check("a5_busy", 32'(busy), 32'd1);
      check("a5_ready", 32'(ready), (k == 7) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("a5_end_busy", 32'(busy), 32'd0);
    check("a5_end_ready", 32'(ready), 32'd1);
    model_line = 1'b0;
    model_ones = 0;

    // 8'hFF then 8'h00 back-to-back, no gap cycle.
    accept_word(8'hFF);
    t0 = $time;
    push_hand(FF_LINES, FF_N);
    push_bits(8'hFF);
    @(negedge clk);
    accept_word(8'h00);
    t1 = $time;
    push_hand(32'h0, 8);
    push_bits(8'h00);
    check("b2b_spacing", 32'((t1 - t0) / 10), 32'(FF_N));
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
    model_line = 1'b0;
    model_ones = 0;

    // Data toggles while busy; only the captured words appear on line.
    @(negedge clk);
    accept_word(8'h3C);
    push_model(8'h3C, W);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k < 7) begin
        data = (k % 2 == 0) ? 8'hFF : 8'h00;
        check("hold_ready_low", 32'(ready), 32'd0);
      end else begin
        data = 8'h96;
        push_model(8'h96, W);
        check("hold_ready_last", 32'(ready), 32'd1);
      end
    end
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
    model_ones = 0;

    // Line holds in IDLE; then reset during bit 3 of 8'hF0.
    @(negedge clk);
    accept_word(8'h01);
    push_model(8'h01, W);
    @(negedge clk);
    valid = 1'b0;
    wait_idle();
    model_ones = 0;
    repeat (3) @(negedge clk);
    check("idle_hold_line", 32'(line), 32'd1);
    accept_word(8'hF0);
    push_model(8'hF0, 3);
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midword_reset_line", 32'(line), 32'd0);
    check("midword_reset_busy", 32'(busy), 32'd0);
    check("midword_reset_ready", 32'(ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_ready", 32'(ready), 32'd1);
    check("after_reset_line", 32'(line), 32'd0);
    check("after_reset_busy", 32'(busy), 32'd0);
    model_line = 1'b0;
    model_ones = 0;

    // Random words streamed back-to-back through the encoder model.
    for (int i = 0; i < 6; i++) begin
      w = W'($urandom);
      accept_word(w);
      push_model(w, W);
      @(negedge clk);
    end
    valid = 1'b0;
    wait_idle();
    model_ones = 0;

    repeat (3) @(negedge clk);
    check("line_queue_drained", 32'(exp_line_q.size()), 32'd0);
    check("bit_queue_drained", 32'(exp_bit_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
